// File: rtl/decode_stage.sv
// Pipeline decode stage: IF/ID register, 32x32 register file with write-through,
// M-stage forwarding, branch/jump resolution and the stall (hazard) detector.
module decode_stage #(
    parameter logic [31:0] RESET_PC4 = 32'h0000_3004,
    parameter logic [31:0] RESET_PC8 = 32'h0000_3008
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IR_F,
    input  logic [31:0] PC4_F,
    input  logic [31:0] PC8_F,
    input  logic        interupt,
    input  logic        int_end,
    input  logic [4:0]  E_wa,
    input  logic        E_we,
    input  logic        E_load,
    input  logic [4:0]  M_wa,
    input  logic        M_we,
    input  logic        M_load,
    input  logic [31:0] M_data,
    input  logic        W_we,
    input  logic [4:0]  W_wa,
    input  logic [31:0] W_data,
    output logic [31:0] IR_D,
    output logic [31:0] PC8_D,
    output logic [31:0] RS_D,
    output logic [31:0] RT_D,
    output logic [31:0] NPC,
    output logic [1:0]  PC_sel,
    output logic        Stall
);

    logic [31:0] r_irD;
    logic [31:0] r_pc4D;
    logic [31:0] r_pc8D;
    logic [31:0] r_gpr [32];

    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [31:0] w_rfRs;
    logic [31:0] w_rfRt;
    logic        w_isBeq;
    logic        w_isBne;
    logic        w_isJ;
    logic        w_isJal;
    logic        w_isJr;
    logic        w_isJalr;
    logic        w_isBr;
    logic        w_rsUse;
    logic        w_rtUse;
    logic        w_brUse;
    logic        w_eBrHit;
    logic        w_mBrHit;
    logic        w_loadUse;
    logic        w_eBrStall;
    logic        w_mBrStall;

    // Flush outranks stall, so an interrupt in a stalled cycle still injects a nop.
    always_ff @(posedge clk) begin
        if (rst || interupt || int_end) begin
            r_irD  <= '0;
            r_pc4D <= RESET_PC4;
            r_pc8D <= RESET_PC8;
        end else if (!Stall) begin
            r_irD  <= IR_F;
            r_pc4D <= PC4_F;
            r_pc8D <= PC8_F;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_gpr[i] <= '0;
            end
        end else if (W_we && (W_wa != 5'd0)) begin
            r_gpr[W_wa] <= W_data;
        end
    end

    assign w_rs    = r_irD[25:21];
    assign w_rt    = r_irD[20:16];
    assign w_op    = r_irD[31:26];
    assign w_funct = r_irD[5:0];

    // Reads see a same-cycle write so W does not need its own forwarding path.
    always_comb begin
        w_rfRs = r_gpr[w_rs];
        if (w_rs == 5'd0) begin
            w_rfRs = '0;
        end else if (W_we && (W_wa == w_rs)) begin
            w_rfRs = W_data;
        end
    end

    always_comb begin
        w_rfRt = r_gpr[w_rt];
        if (w_rt == 5'd0) begin
            w_rfRt = '0;
        end else if (W_we && (W_wa == w_rt)) begin
            w_rfRt = W_data;
        end
    end

    assign RS_D = (M_we && !M_load && (M_wa != 5'd0) && (M_wa == w_rs)) ? M_data : w_rfRs;
    assign RT_D = (M_we && !M_load && (M_wa != 5'd0) && (M_wa == w_rt)) ? M_data : w_rfRt;

    assign w_isBeq  = (w_op == 6'b000100);
    assign w_isBne  = (w_op == 6'b000101);
    assign w_isJ    = (w_op == 6'b000010);
    assign w_isJal  = (w_op == 6'b000011);
    assign w_isJr   = (w_op == 6'b000000) && (w_funct == 6'b001000);
    assign w_isJalr = (w_op == 6'b000000) && (w_funct == 6'b001001);
    assign w_isBr   = w_isBeq || w_isBne;
    assign w_rsUse  = !(w_isJ || w_isJal);
    assign w_rtUse  = (w_op == 6'b000000) || w_isBr || (w_op == 6'b101011);
    assign w_brUse  = w_isBr || w_isJr || w_isJalr;

    // jr/jalr depend on rs only; beq/bne depend on both rs and rt.
    assign w_eBrHit = (E_wa == w_rs) || (w_isBr && (E_wa == w_rt));
    assign w_mBrHit = (M_wa == w_rs) || (w_isBr && (M_wa == w_rt));

    assign w_loadUse  = E_load && (E_wa != 5'd0) &&
                        ((w_rsUse && (E_wa == w_rs)) || (w_rtUse && (E_wa == w_rt)));
    assign w_eBrStall = w_brUse && E_we && (E_wa != 5'd0) && w_eBrHit;
    assign w_mBrStall = w_brUse && M_load && (M_wa != 5'd0) && w_mBrHit;
    assign Stall      = w_loadUse || w_eBrStall || w_mBrStall;

    always_comb begin
        NPC = r_pc4D;
        if (w_isBr) begin
            NPC = r_pc4D + {{14{r_irD[15]}}, r_irD[15:0], 2'b00};
        end else if (w_isJ || w_isJal) begin
            NPC = {r_pc4D[31:28], r_irD[25:0], 2'b00};
        end
    end

    always_comb begin
        PC_sel = 2'b00;
        if (!Stall) begin
            if (w_isJ || w_isJal || (w_isBeq && (RS_D == RT_D)) || (w_isBne && (RS_D != RT_D))) begin
                PC_sel = 2'b01;
            end else if (w_isJr || w_isJalr) begin
                PC_sel = 2'b10;
            end
        end
    end

    assign IR_D  = r_irD;
    assign PC8_D = r_pc8D;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: each cycle's expected D-stage outputs are
// queued with the stimulus and popped for comparison just before the next edge.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic [31:0] IR_F;
    logic [31:0] PC4_F;
    logic [31:0] PC8_F;
    logic        interupt;
    logic        int_end;
    logic [4:0]  E_wa;
    logic        E_we;
    logic        E_load;
    logic [4:0]  M_wa;
    logic        M_we;
    logic        M_load;
    logic [31:0] M_data;
    logic        W_we;
    logic [4:0]  W_wa;
    logic [31:0] W_data;
    logic [31:0] IR_D;
    logic [31:0] PC8_D;
    logic [31:0] RS_D;
    logic [31:0] RT_D;
    logic [31:0] NPC;
    logic [1:0]  PC_sel;
    logic        Stall;

    typedef struct {
        logic [31:0] irD;
        logic [31:0] pc8D;
        logic [31:0] rsD;
        logic [31:0] rtD;
        logic [31:0] npc;
        logic [1:0]  sel;
        logic        stall;
    } expT;

    expT expQ[$];
    int  numChecks = 0;
    int  numFails  = 0;
    int  stepNum   = 0;

    decode_stage dut (
        .clk      (clk),
        .rst      (rst),
        .IR_F     (IR_F),
        .PC4_F    (PC4_F),
        .PC8_F    (PC8_F),
        .interupt (interupt),
        .int_end  (int_end),
        .E_wa     (E_wa),
        .E_we     (E_we),
        .E_load   (E_load),
        .M_wa     (M_wa),
        .M_we     (M_we),
        .M_load   (M_load),
        .M_data   (M_data),
        .W_we     (W_we),
        .W_wa     (W_wa),
        .W_data   (W_data),
        .IR_D     (IR_D),
        .PC8_D    (PC8_D),
        .RS_D     (RS_D),
        .RT_D     (RT_D),
        .NPC      (NPC),
        .PC_sel   (PC_sel),
        .Stall    (Stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        numChecks++;
        if (obs !== exp) begin
            numFails++;
            $display("[TB] FAIL step %0d %s: got %h, expected %h", stepNum, tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs at the falling edge and queues what D must show this cycle.
    task automatic applyStimulus(
        input logic [31:0] irF, input logic [31:0] pc4F,
        input logic intr, input logic iend,
        input logic eWe, input logic eLoad, input logic [4:0] eWa,
        input logic mWe, input logic mLoad, input logic [4:0] mWa, input logic [31:0] mData,
        input logic wWe, input logic [4:0] wWa, input logic [31:0] wData,
        input logic [31:0] xIrD, input logic [31:0] xPc8D, input logic [31:0] xRs,
        input logic [31:0] xRt, input logic [31:0] xNpc, input logic [1:0] xSel, input logic xStall);
        expT e;
        @(negedge clk);
        rst      = 1'b0;
        IR_F     = irF;
        PC4_F    = pc4F;
        PC8_F    = pc4F + 32'd4;
        interupt = intr;
        int_end  = iend;
        E_we     = eWe;
        E_load   = eLoad;
        E_wa     = eWa;
        M_we     = mWe;
        M_load   = mLoad;
        M_wa     = mWa;
        M_data   = mData;
        W_we     = wWe;
        W_wa     = wWa;
        W_data   = wData;
        e.irD = xIrD; e.pc8D = xPc8D; e.rsD = xRs; e.rtD = xRt;
        e.npc = xNpc; e.sel = xSel; e.stall = xStall;
        expQ.push_back(e);
        #3;
        popAndCompare();
        stepNum++;
    endtask

    task automatic popAndCompare();
        expT e;
        if (expQ.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = expQ.pop_front();
            checkOutput("IR_D",   IR_D,           e.irD);
            checkOutput("PC8_D",  PC8_D,          e.pc8D);
            checkOutput("RS_D",   RS_D,           e.rsD);
            checkOutput("RT_D",   RT_D,           e.rtD);
            checkOutput("NPC",    NPC,            e.npc);
            checkOutput("PC_sel", {30'd0, PC_sel}, {30'd0, e.sel});
            checkOutput("Stall",  {31'd0, Stall},  {31'd0, e.stall});
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; IR_F = '0; PC4_F = '0; PC8_F = '0; interupt = 1'b0; int_end = 1'b0;
        E_wa = '0; E_we = 1'b0; E_load = 1'b0; M_wa = '0; M_we = 1'b0; M_load = 1'b0;
        M_data = '0; W_we = 1'b0; W_wa = '0; W_data = '0;
        repeat (2) @(posedge clk);

        //            irF           pc4F          int  E(we,ld,wa)  M(we,ld,wa,data)         W(we,wa,data)              | IR_D          PC8_D         RS_D          RT_D          NPC           sel    stall
        applyStimulus(32'h0000_0000, 32'h0000_3004, 0,0, 0,0,5'd0,  0,0,5'd0,32'h0,          0,5'd0,32'h0,              32'h0000_0000, 32'h0000_3008, 32'h0,        32'h0,        32'h0000_3004, 2'b00, 0);
        applyStimulus(32'h00A0_0820, 32'h0000_3008, 0,0, 0,0,5'd0,  0,0,5'd0,32'h0,          0,5'd0,32'h0,              32'h0000_0000, 32'h0000_3008, 32'h0,        32'h0,        32'h0000_3004, 2'b00, 0);
        applyStimulus(32'h00A0_0820, 32'h0000_300C, 0,0, 0,0,5'd0,  0,0,5'd0,32'h0,          1,5'd5,32'h1234,           32'h00A0_0820, 32'h0000_300C, 32'h1234,     32'h0,        32'h0000_3008, 2'b00, 0);
        applyStimulus(32'h0000_0000, 32'h0000_3010, 0,0, 0,0,5'd0,  0,0,5'd0,32'h0,          1,5'd0,32'hFFFF_FFFF,      32'h00A0_0820, 32'h0000_3010, 32'h1234,     32'h0,        32'h0000_300C, 2'b00, 0);
        applyStimulus(32'h1022_0003, 32'h0000_3010, 0,0, 0,0,5'd0,  0,0,5'd0,32'h0,          1,5'd1,32'h7,              32'h0000_0000, 32'h0000_3014, 32'h0,        32'h0,        32'h0000_3010, 2'b00, 0);
        applyStimulus(32'h1022_0003, 32'h0000_3010, 0,0, 0,0,5'd0,  0,0,5'd0,32'h0,          1,5'd2,32'h7,              32'h1022_0003, 32'h0000_3014, 32'h7,        32'h7,        32'h0000_301C, 2'b01, 0);
        applyStimulus(32'h0085_1820, 32'h0000_3014, 0,0, 0,0,5'd0,  0,0,5'd0,32'h0,          1,5'd2,32'h8,              32'h1022_0003, 32'h0000_3014, 32'h7,        32'h8,        32'h0000_301C, 2'b00, 0);
        applyStimulus(32'h0000_0000, 32'h0000_3018, 0,0, 0,1,5'd4,  0,0,5'd0,32'h0,          0,5'd0,32'h0,              32'h0085_1820, 32'h0000_3018, 32'h0,        32'h1234,     32'h0000_3014, 2'b00, 1);
        applyStimulus(32'h03E0_0008, 32'h0000_3020, 0,0, 0,0,5'd0,  0,0,5'd0,32'h0,          0,5'd0,32'h0,              32'h0085_1820, 32'h0000_3018, 32'h0,        32'h1234,     32'h0000_3014, 2'b00, 0);
        applyStimulus(32'h03E0_0008, 32'h0000_3020, 0,0, 0,0,5'd0,  1,0,5'd31,32'h3100,      0,5'd0,32'h0,              32'h03E0_0008, 32'h0000_3024, 32'h3100,     32'h0,        32'h0000_3020, 2'b10, 0);
        applyStimulus(32'h03E0_0008, 32'h0000_3020, 1,0, 1,0,5'd31, 1,0,5'd31,32'h3100,      0,5'd0,32'h0,              32'h03E0_0008, 32'h0000_3024, 32'h3100,     32'h0,        32'h0000_3020, 2'b00, 1);
        applyStimulus(32'h0800_0100, 32'h3000_0004, 0,0, 1,0,5'd31, 0,0,5'd0,32'h0,          0,5'd0,32'h0,              32'h0000_0000, 32'h0000_3008, 32'h0,        32'h0,        32'h0000_3004, 2'b00, 0);
        applyStimulus(32'h1422_FFFF, 32'h0000_3040, 0,0, 0,0,5'd0,  0,0,5'd0,32'h0,          0,5'd0,32'h0,              32'h0800_0100, 32'h3000_0008, 32'h0,        32'h0,        32'h3000_0400, 2'b01, 0);
        applyStimulus(32'h1422_FFFF, 32'h0000_3040, 0,0, 0,0,5'd0,  0,0,5'd0,32'h0,          0,5'd0,32'h0,              32'h1422_FFFF, 32'h0000_3044, 32'h7,        32'h8,        32'h0000_303C, 2'b01, 0);
        applyStimulus(32'h0000_0000, 32'h0000_3048, 0,0, 0,0,5'd0,  1,1,5'd2,32'hDEAD,       0,5'd0,32'h0,              32'h1422_FFFF, 32'h0000_3044, 32'h7,        32'h8,        32'h0000_303C, 2'b00, 1);
        applyStimulus(32'h0000_0000, 32'h0000_3048, 0,1, 0,1,5'd0,  1,0,5'd2,32'h7,          0,5'd0,32'h0,              32'h1422_FFFF, 32'h0000_3044, 32'h7,        32'h7,        32'h0000_303C, 2'b00, 0);
        applyStimulus(32'h0000_0000, 32'h0000_3050, 0,0, 0,0,5'd0,  0,0,5'd0,32'h0,          0,5'd0,32'h0,              32'h0000_0000, 32'h0000_3008, 32'h0,        32'h0,        32'h0000_3004, 2'b00, 0);

        if (expQ.size() != 0) begin
            checkOutput("scoreboard_leftover", expQ.size(), 32'd0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipeline D stage that sits directly downstream of the fetch stage and consumes IR_F_out, PC4_F_out and PC8_F_out.
- Contains:
  - the IF/ID pipeline register;
  - a 32x32 register file with write-through bypass;
  - M-stage forwarding for branch operands;
  - the branch/jump resolution unit, which drives NPC, RS_D and PC_sel back to fetch;
  - the load-use / branch-dependence hazard detector that produces Stall.
- Branches resolve in D with one architectural delay slot.

Parameters:
- RESET_PC4, 32'h0000_3004, PC4_D value loaded on reset and on flush.
- RESET_PC8, 32'h0000_3008, PC8_D value loaded on reset and on flush.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- IR_F  in  32  instruction from fetch.
- PC4_F  in  32  fetch PC+4.
- PC8_F  in  32  fetch PC+8.
- interupt  in  1  interrupt taken; flushes IF/ID.
- int_end  in  1  eret taken; flushes IF/ID.
- E_wa  in  5  destination register of the instruction in E.
- E_we  in  1  E instruction writes a register.
- E_load  in  1  E instruction is lw.
- M_wa  in  5  destination register of the instruction in M.
- M_we  in  1  M instruction writes a register.
- M_load  in  1  M instruction is lw.
- M_data  in  32  M-stage ALU result, valid when M_we & ~M_load.
- W_we  in  1  register file write enable.
- W_wa  in  5  register file write address.
- W_data  in  32  register file write data.
- IR_D  out  32  instruction held in D.
- PC8_D  out  32  link value for jal/jalr.
- RS_D  out  32  forwarded rs value; also the jr/jalr target.
- RT_D  out  32  forwarded rt value.
- NPC  out  32  branch or jump target.
- PC_sel  out  2  selects the next PC: 00 = PC+4, 01 = NPC, 10 = RS_D.
- Stall  out  1  freezes the fetch PC and IF/ID; a bubble is inserted into E downstream.

Behaviour:
- Reset (rst=1 at a posedge):
  - IR_D = 0.
  - PC4_D = RESET_PC4, PC8_D = RESET_PC8.
  - All 32 GPRs = 0.
  - Combinational outputs then follow from the reset IR_D: PC_sel = 00, Stall = 0, NPC = PC4_D.
- IF/ID update priority, evaluated at each posedge:
  - rst first.
  - Then (interupt | int_end): flush. IR_D = 0 (nop), PC4/PC8_D = reset params.
  - Then Stall: hold all values.
  - Otherwise load IR_F, PC4_F and PC8_F.
  - Flush wins over Stall.
- Register file:
  - Write on posedge when W_we and W_wa != 0. Register 0 always reads 0.
  - Reads are combinational on IR_D[25:21] (rs) and IR_D[20:16] (rt).
  - Write-through bypass: if W_we and W_wa == read address and the address != 0, the read returns W_data in the same cycle.
- Forwarding:
  - Condition: M_we & ~M_load & M_wa != 0 & M_wa == rs (or rt).
  - When it holds, RS_D (or RT_D) = M_data.
  - Otherwise RS_D/RT_D take the register file (bypassed) value.
- Decode, with op = IR_D[31:26] and funct = IR_D[5:0]:
  - beq op=000100, bne op=000101.
  - j op=000010, jal op=000011.
  - jr op=0/funct=001000, jalr op=0/funct=001001.
  - rs_use: every opcode except j and jal.
  - rt_use: op=0, beq, bne, sw (101011).
  - br_use: beq, bne, jr, jalr. For beq/bne the operands are rs and rt; for jr/jalr the operand is rs only.
- NPC:
  - beq/bne: PC4_D + {sext(IR_D[15:0]), 2'b00}, mod 2^32.
  - j/jal: {PC4_D[31:28], IR_D[25:0], 2'b00}.
  - Otherwise: PC4_D.
- PC_sel (forced to 00 whenever Stall=1):
  - 01 for j, jal, beq with RS_D == RT_D, and bne with RS_D != RT_D.
  - 10 for jr/jalr.
  - 00 otherwise.
- Stall is the OR of three terms:
  - (a) E_load & E_wa != 0 & ((rs_use & E_wa == rs) | (rt_use & E_wa == rt)).
  - (b) br_use & E_we & E_wa != 0 & E_wa matches a branch operand.
  - (c) br_use & M_load & M_wa != 0 & M_wa matches a branch operand.
- Register 0 never causes a stall or a forward.
- Stall is purely combinational from IR_D and the E/M inputs; it clears the cycle after the producer advances.
- A flush in a stalled cycle replaces IR_D with a nop, so Stall is 0 in the following cycle.

Test Plan:
- Reset, then IR_F=32'h0000_0000 and PC4_F=32'h3004 for one cycle -> IR_D=0, PC_sel=00, Stall=0, all reads 0.
- Write $5=32'h1234 (W_we=1, W_wa=5), same cycle as IR_D = add $1,$5,$0 -> RS_D=32'h1234 via bypass. Then W_wa=0 with W_data=FFFF_FFFF -> a read of $0 still returns 0.
- IR_D = beq $1,$2,+3 (32'h1022_0003), PC4_D=32'h3010, $1=$2=7 -> PC_sel=01, NPC=32'h301C. With $2=8 -> PC_sel=00.
- IR_D = add $3,$4,$5 while E_load=1, E_wa=4 -> Stall=1 and PC_sel=00 and IF/ID holds. Next cycle E_load=0 -> Stall=0 and IF/ID loads.
- IR_D = jr $31 with M_we=1, M_load=0, M_wa=31, M_data=32'h3100 -> Stall=0, PC_sel=10, RS_D=32'h3100. Same instruction with E_we=1, E_wa=31 -> Stall=1.
- Stall=1 and interupt=1 in the same cycle -> next IR_D=0, PC4_D=32'h3004, Stall=0. j 0x100 (32'h0800_0100) with PC4_D=32'h3000_0004 -> NPC=32'h3000_0400.
